// File: rtl/wb_cmd_master_pkg.sv
// wb_cmd_master_pkg: shared state encoding and default widths for the Wishbone command master
package wb_cmd_master_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
  localparam int ADR_W_DEF = 32;
  localparam int DAT_W_DEF = 32;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/wb_cmd_master_timeout_ctr.sv
// wbm_timeout_ctr: saturating wait counter flagging when MAX un-acked bus cycles have elapsed
module wbm_timeout_ctr
  import wb_cmd_master_pkg::*;
#(
  parameter int MAX = TIMEOUT_DEF,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(MAX);
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-command Wishbone B4 classic initiator; WBM_TIMEOUT_EN adds an ack timeout
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF,
  parameter int SEL_W = DAT_W / 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [DAT_W-1:0] wbm_dat_i
);
  if (DAT_W % 8 != 0 || SEL_W != DAT_W / 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("wb_cmd_master: illegal parameter combination");
  end
  state_t state, state_d;
  logic ack, to_hit, accept, done, rsp_take;
  // an ack is only meaningful while our cycle is open
  assign ack = wbm_ack_i & wbm_cyc_o;
  always_ff @(posedge wb_clk_i) begin
    state <= wb_rst_i ? IDLE : state_d;
  end
  always_comb begin
    state_d = (state == IDLE && cmd_valid) ? BUS :
              (state == BUS && done)       ? RESP :
              (state == RESP && rsp_ready) ? IDLE : state;
  end
  always_comb begin
    cmd_ready = state == IDLE;
    accept    = cmd_ready & cmd_valid;
    done      = (state == BUS) & (ack | to_hit);
    rsp_take  = (state == RESP) & rsp_ready;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      if (accept) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= cmd_we;
        wbm_sel_o <= cmd_sel;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
      end
      if (done) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_dat   <= (ack && !wbm_we_o) ? wbm_dat_i : '0;
      end
      if (rsp_take) rsp_valid <= 1'b0;
    end
  end
`ifdef WBM_TIMEOUT_EN
  logic tc;
  wbm_timeout_ctr #(.MAX(TIMEOUT_CYCLES)) u_to (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .clr     (accept),
    .en      (state == BUS && !ack),
    .tc      (tc)
  );
  // ack in the terminal-count cycle takes priority over the timeout
  assign to_hit = tc & ~ack;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) rsp_err <= 1'b0;
    else if (done) rsp_err <= ~ack;
  end
`else
  assign to_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed plus randomized checks of wb_cmd_master against a transaction-level model
module tb_wb_cmd_master;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i, cmd_valid, cmd_we, rsp_ready, wbm_ack_i;
  logic [31:0] cmd_adr, cmd_dat, wbm_dat_i;
  logic [3:0]  cmd_sel;
  logic        cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] rsp_dat, wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  int checks = 0;
  int errors = 0;

  wb_cmd_master #(.TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One command issued at a negedge; the slave acks after 'waits' stalled cycles and the
  // consumer stalls 'hold' cycles. keep_valid leaves cmd_valid up through the response phase.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int waits, input logic [31:0] rdata,
                     input int hold, input bit keep_valid);
    logic [31:0] exp_dat;
    exp_dat = we ? 32'h0 : rdata;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge wb_clk_i);
    cmd_valid = 0;
    for (int i = 0; i <= waits; i++) begin
      chk("bus_ctl", {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready}, 4'b1100);
      chk("bus_fields", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, {we, sel, adr, dat});
      if (i == waits) begin wbm_ack_i = 1; wbm_dat_i = rdata; end
      else wbm_dat_i = $urandom;
      @(negedge wb_clk_i);
    end
    wbm_ack_i = 0;
    wbm_dat_i = $urandom;
    cmd_valid = keep_valid;
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_ctl", {wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err, cmd_ready}, 5'b00100);
      chk("rsp_dat", rsp_dat, exp_dat);
      if (i == hold) rsp_ready = 1;
      @(negedge wb_clk_i);
    end
    rsp_ready = 0;
    chk("rsp_done", {rsp_valid, cmd_ready, wbm_cyc_o}, 3'b010);
  endtask

  initial begin
    int n;
    wb_rst_i = 1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
    rsp_ready = 0; wbm_ack_i = 0; wbm_dat_i = 0;
    repeat (2) @(negedge wb_clk_i);
    chk("reset_ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err, cmd_ready}, 6'b000001);
    chk("reset_data", {wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_dat}, 0);
    wb_rst_i = 0;
    @(negedge wb_clk_i);
    chk("idle_ready", cmd_ready, 1);
    // read with three wait states
    txn(0, 32'h3000_0004, 32'h0, 4'hF, 3, 32'h0000_0010, 0, 0);
    // zero-wait write
    txn(1, 32'h3000_0000, 32'hA5A5_5A5A, 4'h3, 0, 32'hDEAD_BEEF, 0, 0);
    // back-pressure with the next command already waiting
    txn(0, 32'h3000_0008, 32'h0, 4'hF, 1, 32'h1234_5678, 5, 1);
    txn(0, 32'h3000_0008, 32'h0, 4'hF, 0, 32'h8765_4321, 0, 0);
    // reset during a stalled bus cycle
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_000C; cmd_sel = 4'hF;
    @(negedge wb_clk_i);
    cmd_valid = 0;
    repeat (2) @(negedge wb_clk_i);
    chk("pre_reset_cyc", wbm_cyc_o, 1);
    wb_rst_i = 1;
    @(negedge wb_clk_i);
    chk("mid_reset", {wbm_cyc_o, wbm_stb_o, rsp_valid}, 3'b000);
    wb_rst_i = 0;
    wbm_ack_i = 1; wbm_dat_i = 32'hFFFF_FFFF;
    @(negedge wb_clk_i);
    wbm_ack_i = 0;
    chk("stray_ack", {wbm_cyc_o, rsp_valid, cmd_ready}, 3'b001);
    @(negedge wb_clk_i);
    chk("stray_ack_after", {wbm_cyc_o, rsp_valid, cmd_ready}, 3'b001);
`ifdef WBM_TIMEOUT_EN
    // never acked: cycle aborts after TIMEOUT_CYCLES+1 bus cycles
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0010; cmd_sel = 4'hF;
    @(negedge wb_clk_i);
    cmd_valid = 0;
    n = 0;
    for (int i = 0; i < 20 && wbm_cyc_o; i++) begin n++; @(negedge wb_clk_i); end
    chk("to_cyc_len", n, 5);
    chk("to_rsp", {rsp_valid, rsp_err, rsp_dat}, {2'b11, 32'h0});
    rsp_ready = 1;
    @(negedge wb_clk_i);
    rsp_ready = 0;
    chk("to_done", {rsp_valid, cmd_ready}, 2'b01);
    // ack in the terminal-count cycle still yields a normal response
    txn(0, 32'h3000_0014, 32'h0, 4'hF, 4, 32'hCAFE_F00D, 0, 0);
`else
    // no timeout: a very slow slave still completes normally
    txn(0, 32'h3000_0014, 32'h0, 4'hF, 1000, 32'hCAFE_F00D, 0, 0);
`endif
    for (int k = 0; k < 16; k++)
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom,
          $urandom_range(0, 2), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
